serial_rx_deser: RTL
====================

# serial_rx_deser

- Serial receiver that deserialises an asynchronous, LSB-first, 8N1-style line into an `n`-bit word.
- Presents the word on `DATA` together with a one-cycle `LOAD` strobe.
- Sits directly upstream of the generic `n`-bit holding register: `DATA` drives its `DATA_IN`, `LOAD` drives its `CE`.
- Also flags framing errors (and, when configured, parity errors) so that corrupt words are never loaded.

## Interface

Parameters:
- `n`, 6, data bits per frame; also the `DATA` width.
- `CLKS_PER_BIT`, 868, `CLK` cycles per serial bit (100 MHz / 115200); must be ≥ 4.

Ports:
- `CLK`  in  1  system clock.
- `RESET`  in  1  reset, synchronous, active-high; clock `CLK`.
- `RX`  in  1  asynchronous serial line; idles high.
- `DATA`  out  `n`  last correctly received word; held stable between `LOAD` pulses.
- `LOAD`  out  1  one-cycle strobe marking a new valid `DATA`.
- `FRAME_ERR`  out  1  one-cycle strobe: stop bit sampled low.
- `PAR_ERR`  out  1  one-cycle strobe: parity mismatch; constant 0 when parity is compiled out.

## Operation

- **Input synchroniser:** `RX` passes through a 2-FF synchroniser; the result is `rx_s`. Both FFs reset to 1.
- **States:** IDLE, START, BITS, PARITY (only with the macro), STOP.
- **IDLE:** bit counter held at 0. `rx_s == 0` moves to START.
- **START:** at count `(CLKS_PER_BIT-1)/2` (mid start bit), sample `rx_s`.
  - 0: clear the counter, go to BITS.
  - 1: glitch; return to IDLE with no strobe.
- **BITS:** at count `CLKS_PER_BIT-1`, sample `rx_s`, shift it into the MSB of the shift register (right shift), and clear the counter.
  - After `n` samples, go to PARITY if enabled, otherwise to STOP.
  - The bit index is `$clog2(n)` bits wide and wraps to 0 on exit.
- **PARITY:** at count `CLKS_PER_BIT-1`, sample the parity bit and compare it against the XOR of the shift register (even parity). Result is latched as `par_bad`; go to STOP.
- **STOP:** at count `CLKS_PER_BIT-1`, sample `rx_s`, then always return to IDLE.
  - Sample 1 and `par_bad == 0`: `DATA` ← shift register, pulse `LOAD`.
  - Sample 0: pulse `FRAME_ERR`; `DATA` is unchanged; no `LOAD`.
  - Sample 1 and `par_bad == 1`: pulse `PAR_ERR`; `DATA` is unchanged; no `LOAD`.
- **Error priority:** if the stop bit is low and parity is also bad, `FRAME_ERR` and `PAR_ERR` pulse together in the same cycle; `LOAD` stays 0.
- **Back-to-back frames:** all samples land near mid-bit, so returning to IDLE occurs during the stop bit. A start bit that immediately follows the stop bit is detected.
- **`RX` held low in IDLE:** after a FRAME_ERR, a line still held low is treated as a new start. No lockout is required.
- **Reset:** `RESET` mid-frame aborts to IDLE next cycle with no strobe; the partial word is discarded.

## Timing

- **Reset values:** `DATA` = 0, `LOAD` = 0, `FRAME_ERR` = 0, `PAR_ERR` = 0, state IDLE, counter 0, shift register 0.
- **Outputs:** all registered; no combinational path from `RX`.
- **Strobe timing:** `LOAD` / `FRAME_ERR` / `PAR_ERR` are high for exactly the one cycle after the final stop-bit sample edge. `DATA` updates on that same edge.
- **Downstream register:** captures `DATA` on the next `CLK` edge, i.e. one cycle after `LOAD` rises.
- **Latency:** from the `RX` falling edge to `LOAD` high is 2 (sync) + 1 (IDLE detect) + `(CLKS_PER_BIT-1)/2` + 1 + (`n` + 1 [+1 parity]) × `CLKS_PER_BIT` cycles, ±1.
- **Minimum spacing:** between two `LOAD` pulses is (`n` + 2 [+1]) × `CLKS_PER_BIT` − `CLKS_PER_BIT`/2 cycles.

## Configuration

- **Macro:** `SERIAL_RX_PARITY_CHECK_EN`.
- **Defined:** the frame carries one even-parity bit after the `n` data bits. The PARITY state exists; mismatch pulses `PAR_ERR` and suppresses `LOAD`.
- **Undefined:** the frame has no parity bit, and the PARITY state and `par_bad` logic are absent. `PAR_ERR` is tied to 0; the port stays present so instantiations do not change.

## Structure

- **Shared package `serial_rx_pkg`:**
  - state enum typedef (`RX_IDLE`, `RX_START`, `RX_BITS`, `RX_PARITY`, `RX_STOP`);
  - default `CLKS_PER_BIT`;
  - `function even_parity(input logic [n-1:0])`.
- **Sub-module `baud_tick`:**
  - bit-period counter with inputs `CLK`, `RESET`, `clr`, and parameter `CLKS_PER_BIT`;
  - outputs `mid` (count == `(CLKS_PER_BIT-1)/2`) and `full` (count == `CLKS_PER_BIT-1`);
  - `clr` forces count to 0 and has priority over counting.
- **Top level:** synchroniser, FSM, shift register, output registers.

## Test plan

Bench uses `CLKS_PER_BIT` = 16 and `n` = 6.

1. **Single frame:** send 0x2D (bits 1,0,1,1,0,1 LSB first), valid stop → exactly one `LOAD` pulse, `DATA` = 6'h2D; `FRAME_ERR` and `PAR_ERR` stay 0.
2. **Glitch rejection:** 5-cycle low pulse on `RX` → no strobe, state back to IDLE, `DATA` keeps its previous value.
3. **Framing error:** frame 0x15 with the stop bit low → one `FRAME_ERR` pulse, no `LOAD`, `DATA` unchanged. A following good frame 0x0A yields `LOAD` with `DATA` = 6'h0A.
4. **Back-to-back:** frames 0x3F then 0x00 with zero idle gap → two `LOAD` pulses, spaced 8 × 16 cycles (no parity), `DATA` = 6'h3F then 6'h00.
5. **Reset mid-frame:** assert `RESET` for 1 cycle in the middle of the 3rd data bit → no strobe; `DATA` = 0; the next full frame 0x21 loads correctly.
6. **Parity (macro defined):** 0x07 with parity bit 0 → `PAR_ERR` pulse, no `LOAD`. 0x07 with parity bit 1 → `LOAD` with `DATA` = 6'h07.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial receiver.
// Optional feature macro: SERIAL_RX_PARITY_CHECK_EN (even-parity bit after the data bits).
package serial_rx_pkg;

  // 100 MHz system clock, 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // Widest word the parity helper accepts; narrower words are zero-extended,
  // which leaves the XOR unchanged.
  localparam int PARITY_MAX_W = 32;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_BITS   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Even parity: the parity bit equals the XOR of the data bits
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/serial_rx_deser_baud_tick.sv
// Bit-period counter. 'mid' marks the middle of a bit period, 'full' its end.
// 'clr' restarts the period and wins over counting.
module baud_tick
  import serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  output logic mid,
  output logic full
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] r_count;

  // Free-running period counter; wraps at the end of a bit if nobody clears it
  always_ff @(posedge CLK) begin
    if (RESET || clr) begin
      r_count <= '0;
    end else if (r_count == CNT_W'(CLKS_PER_BIT - 1)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign mid  = (r_count == CNT_W'((CLKS_PER_BIT - 1) / 2));
  assign full = (r_count == CNT_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/serial_rx_deser.sv
// LSB-first 8N1-style serial receiver producing an n-bit word with a LOAD strobe.
// Framing errors (and parity errors when SERIAL_RX_PARITY_CHECK_EN is defined)
// suppress LOAD so corrupt words never reach the downstream holding register.
module serial_rx_deser
  import serial_rx_pkg::*;
#(
  parameter int n            = 6,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         RX,
  output logic [n-1:0] DATA,
  output logic         LOAD,
  output logic         FRAME_ERR,
  output logic         PAR_ERR
);

  localparam int IDX_W = (n > 1) ? $clog2(n) : 1;

  logic [1:0]       r_sync;
  logic             w_rx_s;

  rx_state_t        r_state, w_state_next;
  logic [IDX_W-1:0] r_bit_idx, w_bit_idx_next;
  logic [n-1:0]     r_shift, w_shift_next;
  logic [n-1:0]     r_data, w_data_next;
  logic             r_load, w_load_next;
  logic             r_frame_err, w_frame_err_next;

  logic             w_clr, w_mid, w_full;

`ifdef SERIAL_RX_PARITY_CHECK_EN
  logic             r_par_bad, w_par_bad_next;
  logic             r_par_err, w_par_err_next;
`endif

  // Two-flop synchroniser on the asynchronous line; idles high
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], RX};
    end
  end

  assign w_rx_s = r_sync[1];

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .CLK  (CLK),
    .RESET(RESET),
    .clr  (w_clr),
    .mid  (w_mid),
    .full (w_full)
  );

  // Next-state, datapath and strobe decode
  always_comb begin
    w_state_next     = r_state;
    w_bit_idx_next   = r_bit_idx;
    w_shift_next     = r_shift;
    w_data_next      = r_data;
    w_load_next      = 1'b0;
    w_frame_err_next = 1'b0;
    w_clr            = 1'b0;
`ifdef SERIAL_RX_PARITY_CHECK_EN
    w_par_bad_next   = r_par_bad;
    w_par_err_next   = 1'b0;
`endif

    case (r_state)
      RX_IDLE: begin
        w_clr          = 1'b1;
        w_bit_idx_next = '0;
        if (!w_rx_s) begin
          w_state_next = RX_START;
        end
      end

      RX_START: begin
        // Re-check the line half a bit later so short glitches are ignored
        if (w_mid) begin
          w_clr        = 1'b1;
          w_state_next = w_rx_s ? RX_IDLE : RX_BITS;
        end
      end

      RX_BITS: begin
        if (w_full) begin
          w_clr        = 1'b1;
          w_shift_next = {w_rx_s, r_shift[n-1:1]};
          if (r_bit_idx == IDX_W'(n - 1)) begin
            w_bit_idx_next = '0;
`ifdef SERIAL_RX_PARITY_CHECK_EN
            w_state_next   = RX_PARITY;
`else
            w_state_next   = RX_STOP;
`endif
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end
      end

`ifdef SERIAL_RX_PARITY_CHECK_EN
      RX_PARITY: begin
        if (w_full) begin
          w_clr          = 1'b1;
          w_par_bad_next = w_rx_s ^ even_parity(PARITY_MAX_W'(r_shift));
          w_state_next   = RX_STOP;
        end
      end
`endif

      RX_STOP: begin
        // Sampled mid stop bit, so IDLE is reached early enough to catch
        // a start bit that follows without a gap
        if (w_full) begin
          w_clr            = 1'b1;
          w_state_next     = RX_IDLE;
          w_frame_err_next = !w_rx_s;
`ifdef SERIAL_RX_PARITY_CHECK_EN
          w_par_err_next   = r_par_bad;
          w_load_next      = w_rx_s && !r_par_bad;
`else
          w_load_next      = w_rx_s;
`endif
          if (w_load_next) begin
            w_data_next = r_shift;
          end
        end
      end

      default: begin
        w_clr        = 1'b1;
        w_state_next = RX_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial word
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= RX_IDLE;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_load      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_CHECK_EN
      r_par_bad   <= 1'b0;
      r_par_err   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_bit_idx   <= w_bit_idx_next;
      r_shift     <= w_shift_next;
      r_data      <= w_data_next;
      r_load      <= w_load_next;
      r_frame_err <= w_frame_err_next;
`ifdef SERIAL_RX_PARITY_CHECK_EN
      r_par_bad   <= w_par_bad_next;
      r_par_err   <= w_par_err_next;
`endif
    end
  end

  assign DATA      = r_data;
  assign LOAD      = r_load;
  assign FRAME_ERR = r_frame_err;
`ifdef SERIAL_RX_PARITY_CHECK_EN
  assign PAR_ERR   = r_par_err;
`else
  assign PAR_ERR   = 1'b0;
`endif

endmodule
